// File: rtl/spi_reg_target_pkg.sv
// -----------------------------------------------------------------------------
// spi_reg_target_pkg
//   Shared definitions for the SPI bridge register target:
//   - register addresses of the 8-bit register map
//   - CTRL / STATUS bit indices
//   - bus FSM state type
//   - status_pack(): assembles the STATUS byte from FIFO flags and stickies
// -----------------------------------------------------------------------------
package spi_reg_target_pkg;

    // Register map
    localparam int unsigned REG_CTRL   = 0;
    localparam int unsigned REG_STATUS = 1;
    localparam int unsigned REG_DATA   = 2;
    localparam int unsigned REG_LEVEL  = 3;

    // CTRL bits (7:2 are scratch)
    localparam int unsigned CTRL_CAPTURE_EN = 0;
    localparam int unsigned CTRL_FLUSH      = 1;

    // STATUS bits (7:4 hold the saturated FIFO level)
    localparam int unsigned STAT_EMPTY     = 0;
    localparam int unsigned STAT_FULL      = 1;
    localparam int unsigned STAT_OVERFLOW  = 2;
    localparam int unsigned STAT_UNDERRUN  = 3;
    localparam int unsigned STAT_LEVEL_LSB = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACK  = 2'd1,
        ST_WAIT = 2'd2
    } state_e;

    // Level field is only four bits wide, so a full 16-entry FIFO reads as 15.
    function automatic logic [7:0] status_pack(input logic       empty,
                                               input logic       full,
                                               input logic       ovf,
                                               input logic       unr,
                                               input logic [7:0] level);
        logic [7:0] s;
        s                         = '0;
        s[STAT_EMPTY]             = empty;
        s[STAT_FULL]              = full;
        s[STAT_OVERFLOW]          = ovf;
        s[STAT_UNDERRUN]          = unr;
        s[STAT_LEVEL_LSB +: 4]    = (level > 8'd15) ? 4'hF : level[3:0];
        return s;
    endfunction

endpackage

// File: rtl/spi_reg_target_fifo.sv
// -----------------------------------------------------------------------------
// fifo_sync
//   Synchronous byte FIFO, 2**FSIZE entries, show-ahead read data.
//   Ports:
//     clk_i, rst_ni      clock, asynchronous active-low reset
//     push_i, wdata_i    write request / data (ignored when full)
//     pop_i, rdata_o     read request (ignored when empty) / head of FIFO
//     flush_i            empty the FIFO; takes priority over push and pop
//     empty_o, full_o    status flags
//     level_o            entry count 0..2**FSIZE
// -----------------------------------------------------------------------------
module fifo_sync #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned FSIZE = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             flush_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             empty_o,
    output logic             full_o,
    output logic [FSIZE:0]   level_o
);

    localparam int unsigned DEPTH = 1 << FSIZE;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [FSIZE-1:0] wptr_q, rptr_q;
    logic [FSIZE:0]   level_q;
    logic             do_push, do_pop;

    assign empty_o = (level_q == '0);
    assign full_o  = (level_q == (FSIZE + 1)'(DEPTH));
    assign level_o = level_q;
    assign rdata_o = mem_q[rptr_q];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else if (flush_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + 1'b1;
            if (do_pop)  rptr_q <= rptr_q + 1'b1;
            level_q <= level_q + (FSIZE + 1)'(do_push) - (FSIZE + 1)'(do_pop);
        end
    end

    // Storage carries no reset; contents are only visible once pushed.
    always_ff @(posedge clk_i) begin
        if (do_push && !flush_i) mem_q[wptr_q] <= wdata_i;
    end

endmodule

// File: rtl/spi_reg_target.sv
// -----------------------------------------------------------------------------
// spi_reg_target
//   Wishbone-like bus target behind the SPI slave bridge's master port.
//   8-bit register map: CTRL(0x00) STATUS(0x01) DATA(0x02, pop-on-read)
//   LEVEL(0x03); a sample producer fills the FIFO through a valid/ready stream.
//   Ports:
//     clk_i, rst_ni              clock, asynchronous active-low reset
//     cyc_i stb_i we_i adr_i     bus request (stb_i one cycle per request)
//     dat_i / dat_o              write data / read data (valid with ack_o)
//     ack_o err_o                single-cycle acknowledge / error
//     wat_o                      wait, high while an empty DATA read stalls
//     rty_o                      always 0
//     status_o                   live STATUS byte for the bridge status phase
//     s_valid_i s_data_i         stream byte in
//     s_ready_o                  stream ready (FIFO not full)
//   Build option:
//     SPI_TARGET_STALL_EN  empty DATA reads wait (wat_o) up to STALL_LIMIT
//                          cycles for a byte, then end with err_o.
//                          Undefined: empty DATA read acks 0x00 at once.
// -----------------------------------------------------------------------------
module spi_reg_target
    import spi_reg_target_pkg::*;
#(
    parameter int unsigned      WIDTH       = 8,
    parameter int unsigned      ADDR        = 7,
    parameter int unsigned      FSIZE       = 4,
    parameter logic [WIDTH-1:0] CTRL_INIT   = 8'h00,
    parameter int unsigned      STALL_LIMIT = 15
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             cyc_i,
    input  logic             stb_i,
    input  logic             we_i,
    input  logic [ADDR-1:0]  adr_i,
    input  logic [WIDTH-1:0] dat_i,
    output logic [WIDTH-1:0] dat_o,
    output logic             ack_o,
    output logic             wat_o,
    output logic             rty_o,
    output logic             err_o,
    output logic [WIDTH-1:0] status_o,
    input  logic             s_valid_i,
    output logic             s_ready_o,
    input  logic [WIDTH-1:0] s_data_i
);

    if (WIDTH != 8) begin : g_width_check
        $error("spi_reg_target: WIDTH must be 8");
    end
    if (STALL_LIMIT == 0) begin : g_limit_check
        $error("spi_reg_target: STALL_LIMIT must be at least 1");
    end

    state_e           state_q;
    logic             ack_q, err_q, wat_q;
    logic [WIDTH-1:0] dat_q;
    logic [WIDTH-1:0] ctrl_q, ctrl_d;
    logic             ovf_q, ovf_d, unr_q, unr_d;

    logic             f_empty, f_full;
    logic [FSIZE:0]   f_level;
    logic [WIDTH-1:0] f_rdata;

    logic             accept, wr_acc, rd_acc;
    logic             is_ctrl, is_status, is_data, is_level;
    logic             push, pop, flush;
    logic             ovf_evt, unr_evt, rd_empty_data;
    logic [WIDTH-1:0] status_w, rd_data;

    assign is_ctrl   = (adr_i == ADDR'(REG_CTRL));
    assign is_status = (adr_i == ADDR'(REG_STATUS));
    assign is_data   = (adr_i == ADDR'(REG_DATA));
    assign is_level  = (adr_i == ADDR'(REG_LEVEL));

    assign accept        = (state_q == ST_IDLE) && cyc_i && stb_i;
    assign wr_acc        = accept && we_i;
    assign rd_acc        = accept && !we_i;
    assign rd_empty_data = rd_acc && is_data && f_empty;

    // Flush is a one-shot strobe taken straight from the write; it is never stored.
    assign flush   = wr_acc && is_ctrl && dat_i[CTRL_FLUSH];
    assign push    = s_valid_i && !f_full && ctrl_q[CTRL_CAPTURE_EN];
    assign ovf_evt = s_valid_i && f_full && ctrl_q[CTRL_CAPTURE_EN];

`ifdef SPI_TARGET_STALL_EN
    localparam int unsigned CNT_W = $clog2(STALL_LIMIT + 1);
    logic [CNT_W-1:0] cnt_q;
    logic             in_wait, timeout;

    assign in_wait = (state_q == ST_WAIT) && cyc_i;
    assign timeout = in_wait && f_empty && (cnt_q == CNT_W'(STALL_LIMIT - 1));
    assign pop     = (rd_acc && is_data && !f_empty) || (in_wait && !f_empty);
    assign unr_evt = timeout;
`else
    assign pop     = rd_acc && is_data && !f_empty;
    assign unr_evt = rd_empty_data;
`endif

    fifo_sync #(
        .WIDTH (WIDTH),
        .FSIZE (FSIZE)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (flush),
        .wdata_i (s_data_i),
        .rdata_o (f_rdata),
        .empty_o (f_empty),
        .full_o  (f_full),
        .level_o (f_level)
    );

    assign status_w = status_pack(f_empty, f_full, ovf_q, unr_q, 8'(f_level));

    always_comb begin
        rd_data = '0;
        if (is_ctrl)        rd_data = ctrl_q;
        else if (is_status) rd_data = status_w;
        else if (is_data)   rd_data = f_rdata;
        else if (is_level)  rd_data = WIDTH'(f_level);
    end

    // Register map next state; a same-cycle event wins over a W1C clear.
    always_comb begin
        ctrl_d = ctrl_q;
        ovf_d  = ovf_q;
        unr_d  = unr_q;
        if (wr_acc && is_ctrl) begin
            ctrl_d             = dat_i;
            ctrl_d[CTRL_FLUSH] = 1'b0;
        end
        if (wr_acc && is_status) begin
            if (dat_i[STAT_OVERFLOW]) ovf_d = 1'b0;
            if (dat_i[STAT_UNDERRUN]) unr_d = 1'b0;
        end
        if (ovf_evt) ovf_d = 1'b1;
        if (unr_evt) unr_d = 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ctrl_q <= CTRL_INIT;
            ovf_q  <= 1'b0;
            unr_q  <= 1'b0;
        end else begin
            ctrl_q <= ctrl_d;
            ovf_q  <= ovf_d;
            unr_q  <= unr_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            wat_q   <= 1'b0;
            dat_q   <= '0;
`ifdef SPI_TARGET_STALL_EN
            cnt_q   <= '0;
`endif
        end else begin
            ack_q <= 1'b0;
            err_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        if (rd_empty_data) begin
`ifdef SPI_TARGET_STALL_EN
                            state_q <= ST_WAIT;
                            wat_q   <= 1'b1;
                            cnt_q   <= '0;
`else
                            state_q <= ST_ACK;
                            ack_q   <= 1'b1;
                            dat_q   <= '0;
`endif
                        end else begin
                            state_q <= ST_ACK;
                            ack_q   <= 1'b1;
                            if (!we_i) dat_q <= rd_data;
                        end
                    end
                end
                ST_ACK: begin
                    state_q <= ST_IDLE;
                end
                ST_WAIT: begin
`ifdef SPI_TARGET_STALL_EN
                    if (!cyc_i) begin
                        state_q <= ST_IDLE;
                        wat_q   <= 1'b0;
                    end else if (!f_empty) begin
                        state_q <= ST_ACK;
                        wat_q   <= 1'b0;
                        ack_q   <= 1'b1;
                        dat_q   <= f_rdata;
                    end else if (timeout) begin
                        state_q <= ST_IDLE;
                        wat_q   <= 1'b0;
                        err_q   <= 1'b1;
                        dat_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
`else
                    state_q <= ST_IDLE;
                    wat_q   <= 1'b0;
`endif
                end
                default: begin
                    state_q <= ST_IDLE;
                    wat_q   <= 1'b0;
                end
            endcase
        end
    end

    assign dat_o     = dat_q;
    assign ack_o     = ack_q;
    assign err_o     = err_q;
    assign wat_o     = wat_q;
    assign rty_o     = 1'b0;
    assign status_o  = status_w;
    assign s_ready_o = !f_full;

endmodule

// File: tb/tb_spi_reg_target.sv
module tb_spi_reg_target;

    localparam int unsigned STALL_LIMIT = 15;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cyc = 1'b0, stb = 1'b0, we_s = 1'b0;
    logic [6:0] adr = '0;
    logic [7:0] wdat = '0;
    logic [7:0] dat_o_w, status_w;
    logic       ack_w, wat_w, rty_w, err_w;
    logic       s_valid = 1'b0, s_ready_w;
    logic [7:0] s_data = '0;

    always #5 clk = ~clk;

    spi_reg_target #(
        .WIDTH       (8),
        .ADDR        (7),
        .FSIZE       (4),
        .CTRL_INIT   (8'h00),
        .STALL_LIMIT (STALL_LIMIT)
    ) dut (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .cyc_i     (cyc),
        .stb_i     (stb),
        .we_i      (we_s),
        .adr_i     (adr),
        .dat_i     (wdat),
        .dat_o     (dat_o_w),
        .ack_o     (ack_w),
        .wat_o     (wat_w),
        .rty_o     (rty_w),
        .err_o     (err_w),
        .status_o  (status_w),
        .s_valid_i (s_valid),
        .s_ready_o (s_ready_w),
        .s_data_i  (s_data)
    );

    int n_vec = 0;
    int n_err = 0;

    // Behavioural model: queue of bytes plus register/sticky state.
    logic [7:0] mq [$];
    logic [7:0] m_ctrl = 8'h00;
    bit         m_ovf = 1'b0, m_unr = 1'b0;

    typedef struct {
        bit         we;
        logic [6:0] adr;
        logic [7:0] wd;
        logic [7:0] exp;
    } vec_t;
    vec_t tbl [$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] m_status();
        int unsigned n;
        logic [3:0]  lvl;
        n   = mq.size();
        lvl = (n > 15) ? 4'd15 : 4'(n);
        return {lvl, m_unr, m_ovf, n == 16, n == 0};
    endfunction

    task automatic model_access(input bit we, input logic [6:0] a, input logic [7:0] wd,
                                output logic [7:0] erd, output bit eerr);
        erd  = 8'h00;
        eerr = 1'b0;
        case (a)
            7'h00: begin
                if (we) begin
                    m_ctrl = wd & 8'hFD;
                    if (wd[1]) mq.delete();
                end else erd = m_ctrl;
            end
            7'h01: begin
                if (we) begin
                    if (wd[2]) m_ovf = 1'b0;
                    if (wd[3]) m_unr = 1'b0;
                end else erd = m_status();
            end
            7'h02: begin
                if (!we) begin
                    if (mq.size() > 0) erd = mq.pop_front();
                    else begin
                        m_unr = 1'b1;
`ifdef SPI_TARGET_STALL_EN
                        eerr = 1'b1;
`endif
                    end
                end
            end
            7'h03: if (!we) erd = 8'(mq.size());
            default: ;
        endcase
    endtask

    task automatic bus(input bit we, input logic [6:0] a, input logic [7:0] wd,
                       output logic [7:0] rd, output bit gack, output bit gerr,
                       output int lat, output int wc);
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we_s = we; adr = a; wdat = wd;
        @(posedge clk); #1;
        stb  = 1'b0;
        gack = 1'b0; gerr = 1'b0; lat = 0; wc = 0; rd = '0;
        for (int i = 0; i < 40; i++) begin
            if (ack_w) begin gack = 1'b1; rd = dat_o_w; lat = i; break; end
            if (err_w) begin gerr = 1'b1; rd = dat_o_w; lat = i; break; end
            if (wat_w) wc++;
            @(posedge clk); #1;
        end
        cyc = 1'b0; we_s = 1'b0;
        @(posedge clk); #1;
        chk("handshake_single_cycle", 32'({ack_w, err_w, wat_w}), 32'(0));
    endtask

    task automatic do_op(input string nm, input bit we, input logic [6:0] a,
                         input logic [7:0] wd, output logic [7:0] rd);
        logic [7:0] erd;
        bit         eerr, gack, gerr;
        int         lat, wc;
        model_access(we, a, wd, erd, eerr);
        bus(we, a, wd, rd, gack, gerr, lat, wc);
        if (eerr) begin
            chk({nm, "_err"}, 32'(gerr), 32'(1));
            chk({nm, "_waits"}, 32'(wc), 32'(STALL_LIMIT));
        end else begin
            chk({nm, "_ack"}, 32'(gack), 32'(1));
            chk({nm, "_lat"}, 32'(lat), 32'(0));
        end
        if (!we) chk({nm, "_rd"}, 32'(rd), 32'(erd));
    endtask

    task automatic push_byte(input logic [7:0] d);
        @(negedge clk);
        chk("s_ready", 32'(s_ready_w), 32'(mq.size() < 16));
        s_valid = 1'b1; s_data = d;
        @(posedge clk);
        if (m_ctrl[0]) begin
            if (mq.size() < 16) mq.push_back(d);
            else m_ovf = 1'b1;
        end
        #1 s_valid = 1'b0;
    endtask

    initial begin
        logic [7:0] rd;
        bit         gack, gerr;
        int         lat, wc;

        tbl.push_back('{1'b1, 7'h00, 8'h5D, 8'h00});
        tbl.push_back('{1'b0, 7'h00, 8'h00, 8'h5D});
        tbl.push_back('{1'b0, 7'h01, 8'h00, 8'h01});
        tbl.push_back('{1'b0, 7'h03, 8'h00, 8'h00});
        tbl.push_back('{1'b1, 7'h00, 8'hFE, 8'h00});
        tbl.push_back('{1'b0, 7'h00, 8'h00, 8'hFC});
        tbl.push_back('{1'b1, 7'h05, 8'hAA, 8'h00});
        tbl.push_back('{1'b0, 7'h05, 8'h00, 8'h00});
        tbl.push_back('{1'b0, 7'h7F, 8'h00, 8'h00});
        tbl.push_back('{1'b1, 7'h03, 8'h55, 8'h00});
        tbl.push_back('{1'b0, 7'h03, 8'h00, 8'h00});
        tbl.push_back('{1'b1, 7'h02, 8'h77, 8'h00});
        tbl.push_back('{1'b0, 7'h01, 8'h00, 8'h01});
        tbl.push_back('{1'b1, 7'h00, 8'h01, 8'h00});
        tbl.push_back('{1'b0, 7'h00, 8'h00, 8'h01});

        // Reset state
        @(posedge clk); #1;
        chk("rst_ack", 32'(ack_w), 32'(0));
        chk("rst_wat", 32'(wat_w), 32'(0));
        chk("rst_err", 32'(err_w), 32'(0));
        chk("rst_rty", 32'(rty_w), 32'(0));
        chk("rst_dat", 32'(dat_o_w), 32'(0));
        chk("rst_status", 32'(status_w), 32'(8'h01));
        chk("rst_ready", 32'(s_ready_w), 32'(1));
        @(negedge clk); rst_n = 1'b1;

        // Table-driven register map vectors
        for (int i = 0; i < tbl.size(); i++) begin
            do_op($sformatf("tbl%0d", i), tbl[i].we, tbl[i].adr, tbl[i].wd, rd);
            if (!tbl[i].we) chk($sformatf("tbl%0d_const", i), 32'(rd), 32'(tbl[i].exp));
        end

        // Three pushes, LEVEL then three pops
        push_byte(8'h11); push_byte(8'h22); push_byte(8'h33);
        do_op("lvl3", 1'b0, 7'h03, 8'h00, rd);
        chk("lvl3_const", 32'(rd), 32'(8'h03));
        do_op("pop1", 1'b0, 7'h02, 8'h00, rd); chk("pop1_const", 32'(rd), 32'(8'h11));
        do_op("pop2", 1'b0, 7'h02, 8'h00, rd); chk("pop2_const", 32'(rd), 32'(8'h22));
        do_op("pop3", 1'b0, 7'h02, 8'h00, rd); chk("pop3_const", 32'(rd), 32'(8'h33));
        repeat (3) @(posedge clk);
        #1 chk("dat_hold", 32'(dat_o_w), 32'(8'h33));

`ifdef SPI_TARGET_STALL_EN
        // Byte arrives while the read waits
        fork
            bus(1'b0, 7'h02, 8'h00, rd, gack, gerr, lat, wc);
            begin
                @(negedge clk); @(posedge clk);
                repeat (3) @(posedge clk);
                #1 s_valid = 1'b1; s_data = 8'h9A;
                @(posedge clk); #1 s_valid = 1'b0;
            end
        join
        chk("stall_ack", 32'(gack), 32'(1));
        chk("stall_rd", 32'(rd), 32'(8'h9A));
        chk("stall_wat_cycles", 32'(wc), 32'(5));
        // No byte: timeout
        do_op("stall_to", 1'b0, 7'h02, 8'h00, rd);
        chk("stall_to_dat", 32'(rd), 32'(8'h00));
`else
        do_op("empty_rd", 1'b0, 7'h02, 8'h00, rd);
        chk("empty_rd_const", 32'(rd), 32'(8'h00));
`endif
        do_op("unr_status", 1'b0, 7'h01, 8'h00, rd);
        chk("unr_status_const", 32'(rd), 32'(8'h09));
        do_op("unr_w1c", 1'b1, 7'h01, 8'h08, rd);
        do_op("unr_cleared", 1'b0, 7'h01, 8'h00, rd);
        chk("unr_cleared_const", 32'(rd), 32'(8'h01));

`ifdef SPI_TARGET_STALL_EN
        // cyc_i dropped while waiting: no ack, no pop
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we_s = 1'b0; adr = 7'h02;
        @(posedge clk); #1 stb = 1'b0;
        chk("drop_wat", 32'(wat_w), 32'(1));
        repeat (2) @(posedge clk);
        @(negedge clk); cyc = 1'b0;
        @(posedge clk); #1;
        chk("drop_idle", 32'({ack_w, err_w, wat_w}), 32'(0));
        push_byte(8'h44);
        do_op("drop_level", 1'b0, 7'h03, 8'h00, rd);
        do_op("drop_w1c", 1'b1, 7'h01, 8'h0C, rd);
        do_op("drop_pop", 1'b0, 7'h02, 8'h00, rd);
`endif

        // Fill to 16, then overflow
        for (int i = 0; i < 17; i++) push_byte(8'(8'h40 + i));
        do_op("full_status", 1'b0, 7'h01, 8'h00, rd);
        chk("full_status_const", 32'(rd), 32'(8'hF6));
        do_op("full_level", 1'b0, 7'h03, 8'h00, rd);
        chk("full_level_const", 32'(rd), 32'(8'h10));
        do_op("ovf_w1c", 1'b1, 7'h01, 8'h04, rd);
        do_op("ovf_cleared", 1'b0, 7'h01, 8'h00, rd);
        chk("ovf_cleared_const", 32'(rd), 32'(8'hF2));

        // Flush with a simultaneous push: flush wins
        do_op("pre_flush_pop", 1'b0, 7'h02, 8'h00, rd);
        fork
            do_op("flush_w", 1'b1, 7'h00, 8'h03, rd);
            begin
                @(negedge clk); s_valid = 1'b1; s_data = 8'h66;
                @(posedge clk); #1 s_valid = 1'b0;
            end
        join
        do_op("flush_level", 1'b0, 7'h03, 8'h00, rd);
        chk("flush_level_const", 32'(rd), 32'(8'h00));

        // Push and pop in the same cycle at level 4
        push_byte(8'hA1); push_byte(8'hA2); push_byte(8'hA3); push_byte(8'hA4);
        fork
            do_op("pushpop_rd", 1'b0, 7'h02, 8'h00, rd);
            begin
                @(negedge clk); s_valid = 1'b1; s_data = 8'hEE;
                @(posedge clk); #1 s_valid = 1'b0;
            end
        join
        mq.push_back(8'hEE);
        chk("pushpop_rd_const", 32'(rd), 32'(8'hA1));
        do_op("pushpop_level", 1'b0, 7'h03, 8'h00, rd);
        chk("pushpop_level_const", 32'(rd), 32'(8'h04));

        // Randomized traffic against the model
        for (int k = 0; k < 300; k++) begin
            int unsigned op;
            logic [7:0]  r;
            op = $urandom_range(0, 11);
            r  = 8'($urandom);
            case (op)
                0, 1, 2, 3: push_byte(r);
                4, 5: do_op("rnd_data", 1'b0, 7'h02, 8'h00, rd);
                6:    do_op("rnd_status", 1'b0, 7'h01, 8'h00, rd);
                7:    do_op("rnd_level", 1'b0, 7'h03, 8'h00, rd);
                8:    do_op("rnd_wctrl", 1'b1, 7'h00,
                            {r[7:2], ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) != 0)}, rd);
                9:    do_op("rnd_w1c", 1'b1, 7'h01, r, rd);
                10:   do_op("rnd_ctrl", 1'b0, 7'h00, 8'h00, rd);
                default: do_op("rnd_unmapped", r[0], 7'($urandom_range(4, 127)), r, rd);
            endcase
        end

        // Reset in the middle of an acknowledge
        do_op("mid_cap", 1'b1, 7'h00, 8'h01, rd);
        push_byte(8'h5A);
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we_s = 1'b0; adr = 7'h00;
        @(posedge clk); #1 stb = 1'b0;
        chk("mid_ack_before", 32'(ack_w), 32'(1));
        rst_n = 1'b0;
        #1;
        chk("mid_rst_hs", 32'({ack_w, err_w, wat_w, rty_w}), 32'(0));
        chk("mid_rst_dat", 32'(dat_o_w), 32'(0));
        chk("mid_rst_status", 32'(status_w), 32'(8'h01));
        chk("mid_rst_ready", 32'(s_ready_w), 32'(1));
        cyc = 1'b0;
        mq.delete(); m_ctrl = 8'h00; m_ovf = 1'b0; m_unr = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        do_op("post_rst_ctrl", 1'b0, 7'h00, 8'h00, rd);
        do_op("post_rst_status", 1'b0, 7'h01, 8'h00, rd);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
